branch_resolve: RTL and testbench

Registered branch-resolution stage in the pipelined datapath's execute stage. It consumes the 32-bit magnitude comparator's flags (lt, gt, eq) together with the operand sign bits, and evaluates the RV32I branch condition selected by funct3. It compares the outcome against the fetch-stage prediction and, on a mispredict, issues a one-cycle redirect followed by a fixed-length pipeline flush. It also throttles new branches with a ready signal while a flush is in progress.

---
 rtl/branch_resolve.sv | 186 ++++++++++++++++++
 tb/tb_branch_resolve.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// -----------------------------------------------------------------------------
// branch_resolve
//
// Registered branch-resolution stage for the execute stage. It evaluates the
// RV32I branch condition selected by funct3 from the unsigned magnitude flags
// and the operand sign bits, and compares the result with the fetch-stage
// prediction. A mispredict produces a one-cycle redirect with the corrected
// PC, followed by a FLUSH_CYCLES-long flush. No new branch is accepted while
// that flush is in progress.
//
// Optional feature macro: BRANCH_STATS_EN
//   defined   -> mispred_cnt_o is a saturating count of redirect pulses,
//                cleared only by reset
//   undefined -> the counter is not built and mispred_cnt_o is tied to 0
//
// Parameters:
//   FLUSH_CYCLES  cycles flush_o stays high after a redirect (1..15)
//   CNT_W         width of the mispredict counter
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   valid_i / ready_o   branch handshake; ready_o is low during a flush
//   funct3_i            branch funct3
//   lt_i, gt_i, eq_i    unsigned compare flags for A versus B
//   a_msb_i, b_msb_i    sign bits of A and B
//   pc_i, imm_i         branch PC and sign-extended B-type immediate
//   pred_taken_i        fetch-stage prediction
//   flush_i             external kill from the trap unit
//   valid_o             one-cycle result pulse per accepted branch
//   taken_o, illegal_o  resolved direction; funct3 was 010 or 011
//   redirect_o          one-cycle mispredict pulse
//   redirect_pc_o       corrected fetch PC
//   flush_o             kill younger instructions in IF and ID
//   mispred_cnt_o       saturating mispredict count
// -----------------------------------------------------------------------------
module branch_resolve #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       funct3_i,
  input  logic             lt_i,
  input  logic             gt_i,
  input  logic             eq_i,
  input  logic             a_msb_i,
  input  logic             b_msb_i,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      imm_i,
  input  logic             pred_taken_i,
  input  logic             flush_i,
  output logic             valid_o,
  output logic             taken_o,
  output logic             illegal_o,
  output logic             redirect_o,
  output logic [31:0]      redirect_pc_o,
  output logic             flush_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic        taken_q, taken_d;
  logic        illegal_q, illegal_d;
  logic        redirect_q, redirect_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic        slt;
  logic        cond;
  logic        ill;
  logic        accept;
  logic [31:0] target;

  // gt_i is implied by lt_i and eq_i, so no branch condition needs it.
  logic        gt_unused;
  assign gt_unused = gt_i;

  assign ready_o = (state_q == IDLE);
  assign flush_o = (state_q == FLUSH);

  always_comb begin
    // Differing signs decide signed order on their own; equal signs reduce
    // the signed compare to the unsigned one.
    slt  = (a_msb_i != b_msb_i) ? a_msb_i : lt_i;
    cond = 1'b0;
    ill  = 1'b0;
    case (funct3_i)
      3'b000:  cond = eq_i;
      3'b001:  cond = ~eq_i;
      3'b100:  cond = slt;
      3'b101:  cond = ~slt;
      3'b110:  cond = lt_i;
      3'b111:  cond = ~lt_i;
      default: ill  = 1'b1;
    endcase
    target = pc_i + (cond ? imm_i : 32'd4);
    accept = valid_i & ready_o & ~flush_i;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    valid_d       = 1'b0;
    redirect_d    = 1'b0;
    illegal_d     = 1'b0;
    taken_d       = taken_q;
    redirect_pc_d = redirect_pc_q;
    if (flush_i) begin
      // Trap kill wins over everything but reset; any branch this cycle is lost.
      state_d = IDLE;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            valid_d       = 1'b1;
            taken_d       = cond;
            illegal_d     = ill;
            redirect_pc_d = target;
            if (!ill && (cond != pred_taken_i)) begin
              redirect_d = 1'b1;
              state_d    = FLUSH;
              cnt_d      = 4'(FLUSH_CYCLES);
            end
          end
        end
        FLUSH: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      valid_q       <= 1'b0;
      taken_q       <= 1'b0;
      illegal_q     <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      valid_q       <= valid_d;
      taken_q       <= taken_d;
      illegal_q     <= illegal_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign valid_o       = valid_q;
  assign taken_o       = taken_q;
  assign illegal_o     = illegal_q;
  assign redirect_o    = redirect_q;
  assign redirect_pc_o = redirect_pc_q;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] mis_q, mis_d;

  // Counted on the same edge that raises redirect_o.
  always_comb begin
    mis_d = mis_q;
    if (redirect_d && (mis_q != {CNT_W{1'b1}})) mis_d = mis_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) mis_q <= '0;
    else       mis_q <= mis_d;
  end

  assign mispred_cnt_o = mis_q;
`else
  assign mispred_cnt_o = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;

  localparam int TB_CNT_W = 2;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                valid_i = 1'b0;
  logic                ready_o;
  logic [2:0]          funct3_i = 3'b000;
  logic                lt_i = 1'b0, gt_i = 1'b0, eq_i = 1'b0;
  logic                a_msb_i = 1'b0, b_msb_i = 1'b0;
  logic [31:0]         pc_i = 32'd0, imm_i = 32'd0;
  logic                pred_taken_i = 1'b0;
  logic                flush_i = 1'b0;
  logic                valid_o, taken_o, illegal_o, redirect_o, flush_o;
  logic [31:0]         redirect_pc_o;
  logic [TB_CNT_W-1:0] mispred_cnt_o;

  branch_resolve #(.FLUSH_CYCLES(2), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
    .funct3_i(funct3_i), .lt_i(lt_i), .gt_i(gt_i), .eq_i(eq_i),
    .a_msb_i(a_msb_i), .b_msb_i(b_msb_i), .pc_i(pc_i), .imm_i(imm_i),
    .pred_taken_i(pred_taken_i), .flush_i(flush_i), .valid_o(valid_o),
    .taken_o(taken_o), .illegal_o(illegal_o), .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o), .flush_o(flush_o),
    .mispred_cnt_o(mispred_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        taken;
    logic        illegal;
    logic        redirect;
    logic [31:0] pc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   redirects_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt();
`ifdef BRANCH_STATS_EN
    return (redirects_seen > 3) ? 32'd3 : 32'(redirects_seen);
`else
    return 32'd0;
`endif
  endfunction

  task automatic drive(input logic [2:0] f3, input logic lt, input logic gt, input logic eq,
                       input logic am, input logic bm, input logic [31:0] pc,
                       input logic [31:0] imm, input logic pred);
    valid_i = 1'b1; funct3_i = f3; lt_i = lt; gt_i = gt; eq_i = eq;
    a_msb_i = am; b_msb_i = bm; pc_i = pc; imm_i = imm; pred_taken_i = pred;
  endtask

  task automatic push(input logic t, input logic il, input logic rd, input logic [31:0] pc);
    exp_t e;
    e.taken = t; e.illegal = il; e.redirect = rd; e.pc = pc;
    q.push_back(e);
    if (rd) redirects_seen++;
  endtask

  // One clock; then compare valid_o and, when a result appears, pop the scoreboard.
  task automatic tick(input logic exp_valid);
    exp_t e;
    @(posedge clk);
    #1;
    chk("valid_o", valid_o, exp_valid);
    if (valid_o === 1'b1) begin
      chk("sb_pending", (q.size() > 0), 1'b1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("taken_o", taken_o, e.taken);
        chk("illegal_o", illegal_o, e.illegal);
        chk("redirect_o", redirect_o, e.redirect);
        chk("redirect_pc_o", redirect_pc_o, e.pc);
      end
    end else begin
      chk("redirect_idle", redirect_o, 1'b0);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_flush", flush_o, 1'b0);
    chk("rst_pc", redirect_pc_o, 32'd0);
    chk("rst_cnt", mispred_cnt_o, 32'd0);
    reset = 1'b0;
    tick(1'b0);
    chk("rst_ready", ready_o, 1'b1);

    // BLT signed: A negative, B positive -> taken, mispredicted
    drive(3'b100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h20, 1'b0);
    push(1'b1, 1'b0, 1'b1, 32'h120);
    tick(1'b1);
    valid_i = 1'b0;
    chk("blt_flush1", flush_o, 1'b1);
    chk("blt_ready1", ready_o, 1'b0);
    chk("blt_cnt", mispred_cnt_o, exp_cnt());
    tick(1'b0);
    chk("blt_flush2", flush_o, 1'b1);
    chk("blt_ready2", ready_o, 1'b0);
    tick(1'b0);
    chk("blt_flush_end", flush_o, 1'b0);
    chk("blt_ready_back", ready_o, 1'b1);

    // BGEU correctly predicted, four back-to-back
    for (int i = 0; i < 4; i++) begin
      drive(3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h200 + 32'(4*i), 32'h40, 1'b0);
      push(1'b0, 1'b0, 1'b0, 32'h204 + 32'(4*i));
      tick(1'b1);
      chk("bgeu_ready", ready_o, 1'b1);
      chk("bgeu_flush", flush_o, 1'b0);
    end
    valid_i = 1'b0;
    tick(1'b0);

    // BNE wrap-around, not taken, predicted taken
    drive(3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h10, 1'b1);
    push(1'b0, 1'b0, 1'b1, 32'h0000_0000);
    tick(1'b1);
    valid_i = 1'b0;
    chk("wrap_flush", flush_o, 1'b1);
    chk("wrap_cnt", mispred_cnt_o, exp_cnt());
    tick(1'b0);
    tick(1'b0);
    chk("wrap_ready", ready_o, 1'b1);

    // Illegal funct3 with pred=1: no redirect, stays IDLE
    drive(3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h300, 32'h8, 1'b1);
    push(1'b0, 1'b1, 1'b0, 32'h304);
    tick(1'b1);
    valid_i = 1'b0;
    chk("ill_ready", ready_o, 1'b1);
    chk("ill_flush", flush_o, 1'b0);
    tick(1'b0);
    chk("ill_ready2", ready_o, 1'b1);

    // BGE signed: A positive, B negative -> taken, correctly predicted
    drive(3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h400, 32'hFFFF_FFF0, 1'b1);
    push(1'b1, 1'b0, 1'b0, 32'h3F0);
    tick(1'b1);
    valid_i = 1'b0;
    chk("bge_ready", ready_o, 1'b1);

    // External kill in the second FLUSH cycle, with a branch presented
    drive(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h500, 32'h100, 1'b0);
    push(1'b1, 1'b0, 1'b1, 32'h600);
    tick(1'b1);
    valid_i = 1'b0;
    tick(1'b0);
    chk("killA_flush_c2", flush_o, 1'b1);
    drive(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h700, 32'h100, 1'b0);
    flush_i = 1'b1;
    tick(1'b0);
    chk("killA_flush", flush_o, 1'b0);
    chk("killA_ready", ready_o, 1'b1);
    flush_i = 1'b0; valid_i = 1'b0;
    tick(1'b0);

    // flush_i in IDLE drops a mispredicting branch
    drive(3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h800, 32'h44, 1'b0);
    flush_i = 1'b1;
    tick(1'b0);
    chk("killB_flush", flush_o, 1'b0);
    chk("killB_ready", ready_o, 1'b1);
    flush_i = 1'b0; valid_i = 1'b0;
    tick(1'b0);

    // flush_i in the first FLUSH cycle cuts the flush short
    drive(3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h900, 32'h44, 1'b0);
    push(1'b1, 1'b0, 1'b1, 32'h944);
    tick(1'b1);
    valid_i = 1'b0;
    flush_i = 1'b1;
    tick(1'b0);
    chk("killC_flush", flush_o, 1'b0);
    chk("killC_ready", ready_o, 1'b1);
    flush_i = 1'b0;

    // Reset in the first FLUSH cycle
    drive(3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hA00, 32'h10, 1'b0);
    push(1'b1, 1'b0, 1'b1, 32'hA10);
    tick(1'b1);
    valid_i = 1'b0;
    reset = 1'b1;
    redirects_seen = 0;
    tick(1'b0);
    chk("rstf_flush", flush_o, 1'b0);
    chk("rstf_taken", taken_o, 1'b0);
    chk("rstf_pc", redirect_pc_o, 32'd0);
    chk("rstf_illegal", illegal_o, 1'b0);
    chk("rstf_cnt", mispred_cnt_o, 32'd0);
    reset = 1'b0;
    tick(1'b0);
    chk("rstf_flush2", flush_o, 1'b0);
    chk("rstf_ready", ready_o, 1'b1);

    // Five mispredicts: counter saturates at 3 with CNT_W=2
    for (int i = 0; i < 5; i++) begin
      drive(3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1000 + 32'(16*i), 32'h80, 1'b0);
      push(1'b1, 1'b0, 1'b1, 32'h1080 + 32'(16*i));
      tick(1'b1);
      valid_i = 1'b0;
      chk("stat_cnt", mispred_cnt_o, exp_cnt());
      tick(1'b0);
      tick(1'b0);
    end
    chk("stat_final", mispred_cnt_o, exp_cnt());
    chk("sb_drain", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
